axi2per_req_sched: RTL and testbench

// - Request scheduler in front of the AXI-to-peripheral bridge response path. Arbitrates single-beat AXI reads (AR) and writes (AW+W).
// - Issues one peripheral transaction at a time and emits the trans_* control pulse that the response channel latches.
// - Blocks new requests until the response channel reports the AXI response accepted. Exactly one transaction is outstanding.

---
 rtl/axi2per_req_sched.sv | 129 ++++++++++++
 tb/tb_axi2per_req_sched.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/axi2per_req_sched.sv
// rtl/axi2per_req_sched.sv - single-outstanding AXI read/write request scheduler for the peripheral bridge
// Define AXI2PER_RR_ARB_EN for read/write round-robin; the default is write-over-read fixed priority.
module axi2per_req_sched #(
  parameter int unsigned PER_ADDR_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        ar_valid_i,
  output logic                        ar_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr_i,
  input  logic [AXI_ID_WIDTH-1:0]     ar_id_i,
  input  logic                        aw_valid_i,
  output logic                        aw_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr_i,
  input  logic [AXI_ID_WIDTH-1:0]     aw_id_i,
  input  logic                        aw_atop_r_i,
  input  logic                        w_valid_i,
  output logic                        w_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   w_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] w_strb_i,
  output logic                        per_req_o,
  input  logic                        per_gnt_i,
  output logic [PER_ADDR_WIDTH-1:0]   per_add_o,
  output logic                        per_we_o,
  output logic [31:0]                 per_wdata_o,
  output logic [3:0]                  per_be_o,
  output logic                        trans_req_o,
  output logic                        trans_we_o,
  output logic                        trans_atop_r_o,
  output logic [AXI_ID_WIDTH-1:0]     trans_id_o,
  output logic [AXI_ADDR_WIDTH-1:0]   trans_add_o,
  input  logic                        trans_done_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e                      state_q;
  logic                        rd_cand, wr_cand, rd_win, wr_win;
  logic                        we_q, atop_q;
  logic [AXI_ID_WIDTH-1:0]     id_q;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]                 wdata_q;
  logic [3:0]                  be_q;

`ifdef AXI2PER_RR_ARB_EN
  logic rr_q;  // 1 = write preferred on the next tie
`endif

  always_comb begin
    rd_cand = ar_valid_i;
    wr_cand = aw_valid_i & w_valid_i;
`ifdef AXI2PER_RR_ARB_EN
    wr_win  = wr_cand & (~rd_cand | rr_q);
`else
    wr_win  = wr_cand;
`endif
    rd_win  = rd_cand & ~wr_win;
  end

  assign ar_ready_o = (state_q == IDLE) & rd_win;
  assign aw_ready_o = (state_q == IDLE) & wr_win;
  assign w_ready_o  = (state_q == IDLE) & wr_win;

  assign per_req_o      = (state_q == REQ);
  assign per_add_o      = addr_q[PER_ADDR_WIDTH-1:0];
  assign per_we_o       = we_q;
  assign per_wdata_o    = wdata_q;
  assign per_be_o       = be_q;
  assign trans_req_o    = (state_q == REQ) & per_gnt_i;
  assign trans_we_o     = we_q;
  assign trans_atop_r_o = atop_q;
  assign trans_id_o     = id_q;
  assign trans_add_o    = addr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      atop_q  <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
`ifdef AXI2PER_RR_ARB_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_win) begin
            state_q <= REQ;
            we_q    <= 1'b0;
            atop_q  <= aw_atop_r_i;
            id_q    <= aw_id_i;
            addr_q  <= aw_addr_i;
            // Pick the 32-bit lane of the 64-bit beat that this word address hits
            wdata_q <= aw_addr_i[2] ? w_data_i[63:32] : w_data_i[31:0];
            be_q    <= aw_addr_i[2] ? w_strb_i[7:4]   : w_strb_i[3:0];
`ifdef AXI2PER_RR_ARB_EN
            rr_q    <= 1'b0;
`endif
          end else if (rd_win) begin
            state_q <= REQ;
            we_q    <= 1'b1;
            atop_q  <= 1'b0;
            id_q    <= ar_id_i;
            addr_q  <= ar_addr_i;
            wdata_q <= '0;
            be_q    <= 4'hF;
`ifdef AXI2PER_RR_ARB_EN
            rr_q    <= 1'b1;
`endif
          end
        end
        REQ: begin
          if (per_gnt_i) state_q <= WAIT;
        end
        WAIT: begin
          if (trans_done_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi2per_req_sched.sv
// tb/tb_axi2per_req_sched.sv - randomized self-checking bench for axi2per_req_sched
// Transaction-level reference model; honours AXI2PER_RR_ARB_EN like the design.
module tb_axi2per_req_sched;
  localparam int PAW = 32;
  localparam int AAW = 32;
  localparam int IDW = 3;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic            ar_valid, ar_ready, aw_valid, aw_ready, aw_atop_r, w_valid, w_ready;
  logic [AAW-1:0]  ar_addr, aw_addr;
  logic [IDW-1:0]  ar_id, aw_id;
  logic [63:0]     w_data;
  logic [7:0]      w_strb;
  logic            per_req, per_gnt, per_we;
  logic [PAW-1:0]  per_add;
  logic [31:0]     per_wdata;
  logic [3:0]      per_be;
  logic            trans_req, trans_we, trans_atop_r, trans_done;
  logic [IDW-1:0]  trans_id;
  logic [AAW-1:0]  trans_add;

  axi2per_req_sched #(
    .PER_ADDR_WIDTH(PAW), .AXI_ADDR_WIDTH(AAW), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(IDW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_addr_i(ar_addr), .ar_id_i(ar_id),
    .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_addr_i(aw_addr), .aw_id_i(aw_id),
    .aw_atop_r_i(aw_atop_r),
    .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data), .w_strb_i(w_strb),
    .per_req_o(per_req), .per_gnt_i(per_gnt), .per_add_o(per_add), .per_we_o(per_we),
    .per_wdata_o(per_wdata), .per_be_o(per_be),
    .trans_req_o(trans_req), .trans_we_o(trans_we), .trans_atop_r_o(trans_atop_r),
    .trans_id_o(trans_id), .trans_add_o(trans_add), .trans_done_i(trans_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: which side wins the next tie, and the transaction expected on the peripheral side
  bit              pref_wr = 1'b0;
  logic [AAW-1:0]  e_addr;
  logic [IDW-1:0]  e_id;
  logic            e_we, e_atop;
  logic [31:0]     e_wdata;
  logic [3:0]      e_be;
  string           grant_log;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic randomize_inputs(input bit force_both);
    ar_addr   = $urandom;
    aw_addr   = $urandom;
    ar_id     = IDW'($urandom);
    aw_id     = IDW'($urandom);
    aw_atop_r = 1'($urandom);
    w_data    = {$urandom, $urandom};
    w_strb    = 8'($urandom);
    ar_valid  = force_both ? 1'b1 : 1'($urandom);
    aw_valid  = force_both ? 1'b1 : 1'($urandom);
    w_valid   = force_both ? 1'b1 : 1'($urandom);
  endtask

  task automatic check_no_ready(input string tag);
    check_eq({tag, "_ar_ready"}, ar_ready, 0);
    check_eq({tag, "_aw_ready"}, aw_ready, 0);
    check_eq({tag, "_w_ready"},  w_ready,  0);
  endtask

  task automatic run_trial(input bit force_both, input int stall, input int hold);
    bit rd_c, wr_c, g_wr, g_rd;
    @(negedge clk);
    randomize_inputs(force_both);
    per_gnt    = 1'($urandom);
    trans_done = 1'($urandom);
    #1;
    rd_c = ar_valid;
    wr_c = aw_valid && w_valid;
`ifdef AXI2PER_RR_ARB_EN
    g_wr = wr_c && (!rd_c || pref_wr);
`else
    g_wr = wr_c;
`endif
    g_rd = rd_c && !g_wr;
    check_eq("idle_ar_ready", ar_ready, g_rd);
    check_eq("idle_aw_ready", aw_ready, g_wr);
    check_eq("idle_w_ready",  w_ready,  g_wr);
    check_eq("idle_per_req",  per_req,  0);
    check_eq("idle_trans_req", trans_req, 0);
    if (!g_rd && !g_wr) return;
    grant_log = {grant_log, g_wr ? "W" : "R"};
    if (g_wr) begin
      e_addr  = aw_addr; e_id = aw_id; e_we = 1'b0; e_atop = aw_atop_r;
      e_wdata = aw_addr[2] ? w_data[63:32] : w_data[31:0];
      e_be    = aw_addr[2] ? w_strb[7:4] : w_strb[3:0];
    end else begin
      e_addr  = ar_addr; e_id = ar_id; e_we = 1'b1; e_atop = 1'b0;
      e_wdata = 32'h0; e_be = 4'hF;
    end
    pref_wr = g_rd;
    for (int i = 0; i <= stall; i++) begin
      @(negedge clk);
      randomize_inputs(1'b0);
      per_gnt    = (i == stall);
      trans_done = 1'($urandom);
      #1;
      check_eq("req_per_req",   per_req,   1);
      check_eq("req_per_add",   per_add,   e_addr[PAW-1:0]);
      check_eq("req_per_we",    per_we,    e_we);
      check_eq("req_per_wdata", per_wdata, e_wdata);
      check_eq("req_per_be",    per_be,    e_be);
      check_eq("req_trans_req", trans_req, per_gnt);
      check_no_ready("req");
      if (per_gnt) begin
        check_eq("trans_we",     trans_we,     e_we);
        check_eq("trans_atop_r", trans_atop_r, e_atop);
        check_eq("trans_id",     trans_id,     e_id);
        check_eq("trans_add",    trans_add,    e_addr);
      end
    end
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk);
      randomize_inputs(1'b0);
      per_gnt    = 1'($urandom);
      trans_done = (i == hold);
      #1;
      check_eq("wait_per_req",   per_req,   0);
      check_eq("wait_trans_req", trans_req, 0);
      check_no_ready("wait");
    end
  endtask

  task automatic clear_inputs();
    ar_valid = 0; aw_valid = 0; w_valid = 0; per_gnt = 0; trans_done = 0;
    ar_addr = '0; aw_addr = '0; ar_id = '0; aw_id = '0; aw_atop_r = 0; w_data = '0; w_strb = '0;
  endtask

  initial begin
    string exp_log;
    clear_inputs();
    rst_ni = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_per_req",   per_req,   0);
    check_eq("rst_trans_req", trans_req, 0);
    check_eq("rst_per_add",   per_add,   0);
    check_eq("rst_per_be",    per_be,    0);
    check_eq("rst_trans_id",  trans_id,  0);
    check_no_ready("rst");
    rst_ni = 1'b1;

    grant_log = "";
    for (int k = 0; k < 4; k++) run_trial(1'b1, 0, 0);
`ifdef AXI2PER_RR_ARB_EN
    exp_log = "RWRW";
`else
    exp_log = "WWWW";
`endif
    n_tests++;
    if (grant_log != exp_log) begin
      n_fail++;
      $display("FAIL tie_order: got %s expected %s", grant_log, exp_log);
    end

    for (int k = 0; k < 200; k++)
      run_trial(1'b0, $urandom_range(0, 5), $urandom_range(0, 3));

    @(negedge clk);
    clear_inputs();
    ar_valid = 1'b1; ar_addr = 32'h1004; ar_id = 3'd2;
    #1;
    check_eq("mid_rst_ar_ready", ar_ready, 1);
    @(negedge clk);
    clear_inputs();
    per_gnt = 1'b1;
    #1;
    check_eq("mid_rst_pre_trans_req", trans_req, 1);
    rst_ni = 1'b0;
    #1;
    check_eq("mid_rst_per_req",   per_req,   0);
    check_eq("mid_rst_trans_req", trans_req, 0);
    check_eq("mid_rst_per_add",   per_add,   0);
    @(negedge clk);
    per_gnt = 1'b0;
    rst_ni  = 1'b1;
    pref_wr = 1'b0;
    for (int k = 0; k < 20; k++)
      run_trial(1'b0, $urandom_range(0, 2), $urandom_range(0, 2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
